// File: rtl/div_32b_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, MSB first.
// Divide-by-zero completes immediately with an all-ones quotient and a flag.
module div_32b_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [5:0] LAST = 6'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [5:0]       cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             accept;

    assign accept = start && (state_q != CALC);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = (divisor == '0) ? DONE : CALC;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Quotient bits shift into the dividend register as dividend bits shift out.
    always_comb begin
        trial   = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
        q_bit   = ~trial[WIDTH];
        rem_nxt = q_bit ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
        quo_nxt = {dvd_q[WIDTH-2:0], q_bit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                dvd_q <= dividend;
                dvs_q <= divisor;
                rem_q <= '0;
                cnt_q <= '0;
            end
        end else if (state_q == CALC) begin
            dvd_q <= quo_nxt;
            rem_q <= rem_nxt;
            cnt_q <= cnt_q + 6'd1;
            if (cnt_q == LAST) begin
                quotient    <= quo_nxt;
                remainder   <= rem_nxt;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

endmodule

// File: tb/tb_div_32b_seq.sv
// Scoreboard bench for div_32b_seq: stimulus pushes expected results, a monitor
// pops and checks them (values, latency, identity) whenever done is seen.
module tb_div_32b_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div_32b_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done seen must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_done: got done=%0b with no request pending (cycle %0d)",
                         done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_by_zero", div_by_zero, e.z);
                chk("latency", cyc, e.cyc);
                if (e.b != 0) begin
                    chk("identity", 64'(quotient) * 64'(e.b) + 64'(remainder), 64'(e.a));
                    chk("rem_lt_divisor", remainder < e.b, 1);
                end
            end
        end
    end

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit push);
        exp_t e;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.a   = a;
            e.b   = b;
            e.q   = (b == 0) ? 32'hFFFF_FFFF : a / b;
            e.r   = (b == 0) ? a : a % b;
            e.z   = (b == 0);
            e.cyc = (b == 0) ? cyc : cyc + 32;
            sb.push_back(e);
        end
    endtask

    // Returns at the negedge where done is visible.
    task automatic wait_done(input bit zero);
        bit busy_ok = 1'b1;
        bit seen = 1'b0;
        if (zero) begin
            @(negedge clk);
            chk("dz_done", done, 1);
            chk("dz_busy", busy, 0);
            return;
        end
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        chk("done_timeout", seen, 1);
        chk("busy_while_calc", busy_ok, 1);
        chk("busy_at_done", busy, 0);
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b);
        issue(a, b, 1'b1);
        wait_done(b == 0);
    endtask

    initial begin
        #1;
        chk("reset_q", quotient, 0);
        chk("reset_r", remainder, 0);
        chk("reset_flags", {busy, done, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 100/7, then done must drop the cycle after
        run(32'd100, 32'd7);
        @(negedge clk);
        chk("done_single_cycle", done, 0);

        // Back-to-back: start held in DONE
        run(32'hFFFF_FFFF, 32'd1);
        run(32'd5, 32'd9);
        @(negedge clk);

        run(32'd1234, 32'd0);
        @(negedge clk);
        chk("dz_idle_busy", busy, 0);

        // Start pulse during CALC is ignored
        issue(32'd1000, 32'd10, 1'b1);
        repeat (10) @(negedge clk);
        issue(32'd7, 32'd7, 1'b0);
        wait_done(1'b0);
        @(negedge clk);

        // Reset mid-CALC with start held high during reset
        issue(32'd50, 32'd3, 1'b0);
        repeat (15) @(negedge clk);
        reset    = 1'b1;
        start    = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd0;
        #1;
        chk("midreset_q", quotient, 0);
        chk("midreset_r", remainder, 0);
        chk("midreset_flags", {busy, done, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        chk("reset_ignores_start", {busy, done}, 0);
        start = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("post_reset_idle", {busy, done, div_by_zero}, 0);
        run(32'd50, 32'd3);
        @(negedge clk);

        // Random operand pairs, with forced divisor 0/1 cases and random back-to-back
        for (int i = 0; i < 1000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = (i % 7 == 3) ? 32'($urandom_range(0, 255)) : $urandom;
            case (i % 10)
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'($urandom_range(2, 100));
                3:       b = 32'hFFFF_FFFF;
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            run(a, b);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
